// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter between the single-cycle writeback (A) and the
// long-latency unit (B): round-robin on contention, same-address merge, r0 suppression.
module regfile_wr_arbiter (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wa,
  input  logic [31:0] a_wd,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wa,
  input  logic [31:0] b_wd,
  output logic        b_ready,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  output logic [15:0] conflict_cnt
);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

  pri_e        rr_q, rr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q;
  logic [4:0]  wa_q;
  logic [31:0] wd_q;

  logic        conflict;
  logic        write_d;
  logic [4:0]  sel_wa;
  logic [31:0] sel_wd;
  logic        a_wait, b_wait;

  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    conflict = 1'b0;
    rr_d     = rr_q;
    if (!cpu_rst) begin
      if (a_valid && b_valid) begin
        // Equal addresses (including both r0) merge: A is younger, so its data wins.
        if (a_wa == b_wa) begin
          a_ready = 1'b1;
          b_ready = 1'b1;
        end else begin
          conflict = 1'b1;
          if (rr_q == PRI_A) begin
            a_ready = 1'b1;
            rr_d    = PRI_B;
          end else begin
            b_ready = 1'b1;
            rr_d    = PRI_A;
          end
        end
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  always_comb begin
    sel_wa = '0;
    sel_wd = '0;
    if (a_ready) begin
      sel_wa = a_wa;
      sel_wd = a_wd;
    end else if (b_ready) begin
      sel_wa = b_wa;
      sel_wd = b_wd;
    end
    write_d = (a_ready || b_ready) && (sel_wa != 5'd0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign a_wait = a_valid && !a_ready && !cpu_rst;
  assign b_wait = b_valid && !b_ready && !cpu_rst;
  assign busy1  = (ra1 != 5'd0) && ((a_wait && (ra1 == a_wa)) || (b_wait && (ra1 == b_wa)));
  assign busy2  = (ra2 != 5'd0) && ((a_wait && (ra2 == a_wa)) || (b_wait && (ra2 == b_wa)));

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      rr_q  <= PRI_A;
      cnt_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      we_q  <= write_d;
      // Suppressed r0 writes leave the address/data bus untouched.
      if (write_d) begin
        wa_q <= sel_wa;
        wd_q <= sel_wd;
      end
    end
  end

  assign we           = we_q;
  assign wa           = wa_q;
  assign wd           = wd_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vectors plus a per-cycle behavioural model.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_wa = '0, b_wa = '0, ra1 = '0, ra2 = '0;
  logic [31:0] a_wd = '0, b_wd = '0;
  logic        a_ready, b_ready, we, busy1, busy2;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [15:0] conflict_cnt;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  regfile_wr_arbiter dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (cpu_rst),
    .a_valid     (a_valid),
    .a_wa        (a_wa),
    .a_wd        (a_wd),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_wa        (b_wa),
    .b_wd        (b_wd),
    .b_ready     (b_ready),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who is owed the port, what lands on the bus next cycle.
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int unsigned m_turn_b = 0;
  int unsigned m_cnt = 0;

  always @(negedge clk) begin
    logic ga, gb, eb1, eb2;
    if (cpu_rst) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_turn_b = 0; m_cnt = 0;
    end
    chk("model_we", we, m_we);
    chk("model_wa", wa, m_wa);
    chk("model_wd", wd, m_wd);
    chk("model_cnt", conflict_cnt, m_cnt);
    ga = 1'b0; gb = 1'b0;
    if (!cpu_rst) begin
      if (a_valid && b_valid && a_wa != b_wa) begin
        ga = (m_turn_b == 0);
        gb = (m_turn_b == 1);
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
    end
    eb1 = (ra1 != 0) && ((a_valid && !ga && ra1 == a_wa) || (b_valid && !gb && ra1 == b_wa)) && !cpu_rst;
    eb2 = (ra2 != 0) && ((a_valid && !ga && ra2 == a_wa) || (b_valid && !gb && ra2 == b_wa)) && !cpu_rst;
    chk("model_a_ready", a_ready, ga);
    chk("model_b_ready", b_ready, gb);
    chk("model_busy1", busy1, eb1);
    chk("model_busy2", busy2, eb2);
    if (!cpu_rst) begin
      if (a_valid && b_valid && a_wa != b_wa) begin
        m_turn_b = 1 - m_turn_b;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      m_we = 1'b0;
      if (ga && a_wa != 0) begin
        m_we = 1'b1; m_wa = a_wa; m_wd = a_wd;
      end else if (!ga && gb && b_wa != 0) begin
        m_we = 1'b1; m_wa = b_wa; m_wd = b_wd;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_we", we, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_a_ready", a_ready, 0);
    step(); cpu_rst = 1'b0;
    at_neg();
    chk("post_rst_wd", wd, 0);

    // Single request from A
    step(); a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'h1234;
    at_neg(); chk("single_a_ready", a_ready, 1);
    step(); a_valid = 1'b0;
    at_neg();
    chk("single_we", we, 1);
    chk("single_wa", wa, 3);
    chk("single_wd", wd, 32'h1234);
    step(); at_neg(); chk("single_we_drop", we, 0);

    // Contention: A,B,A,B with B's address watched on ra1
    step(); a_valid = 1'b1; a_wa = 5'd5; a_wd = 32'h55; b_valid = 1'b1; b_wa = 5'd6; b_wd = 32'h66; ra1 = 5'd6;
    at_neg(); chk("cont1_a", a_ready, 1); chk("cont1_b", b_ready, 0); chk("cont1_busy1", busy1, 1);
    step(); at_neg(); chk("cont2_b", b_ready, 1); chk("cont2_busy1", busy1, 0); chk("cont2_wa", wa, 5);
    step(); at_neg(); chk("cont3_a", a_ready, 1); chk("cont3_wa", wa, 6);
    step(); at_neg(); chk("cont4_b", b_ready, 1);
    step(); a_valid = 1'b0; b_valid = 1'b0; ra1 = '0;
    at_neg(); chk("cont_cnt", conflict_cnt, 4); chk("cont_last_wd", wd, 32'h66);

    // Same address: merge, A's data, pointer untouched (still A)
    step(); a_valid = 1'b1; b_valid = 1'b1; a_wa = 5'd7; b_wa = 5'd7; a_wd = 32'hAAAA; b_wd = 32'hBBBB;
    at_neg(); chk("same_a", a_ready, 1); chk("same_b", b_ready, 1);
    step(); b_wa = 5'd8;
    at_neg();
    chk("same_we", we, 1); chk("same_wa", wa, 7); chk("same_wd", wd, 32'hAAAA);
    chk("same_rr_a", a_ready, 1); chk("same_cnt", conflict_cnt, 4);
    step(); a_valid = 1'b0; b_valid = 1'b0;
    at_neg(); chk("same_cnt5", conflict_cnt, 5);

    // Zero address from B alone
    step(); b_valid = 1'b1; b_wa = 5'd0; b_wd = 32'hDEAD;
    at_neg(); chk("zero_b_ready", b_ready, 1);
    step(); b_valid = 1'b0;
    at_neg(); chk("zero_we", we, 0); chk("zero_wa_hold", wa, 7);

    // Reset mid-operation (pointer currently favours B)
    step(); a_valid = 1'b1; a_wa = 5'd9; a_wd = 32'h99; b_valid = 1'b1; b_wa = 5'd10; b_wd = 32'h1010;
    at_neg(); chk("pre_rst_b", b_ready, 1);
    step(); at_neg(); chk("pre_rst_a", a_ready, 1);
    @(posedge clk); #3;
    chk("pre_rst_we", we, 1);
    cpu_rst = 1'b1;
    #1;
    chk("async_we", we, 0);
    chk("async_cnt", conflict_cnt, 0);
    chk("async_a_ready", a_ready, 0);
    at_neg();
    step(); cpu_rst = 1'b0;
    at_neg(); chk("post_rst_a_first", a_ready, 1); chk("post_rst_b_wait", b_ready, 0);

    // Saturation under continuous contention
    repeat (70000) @(posedge clk);
    at_neg(); chk("sat_cnt", conflict_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    at_neg(); chk("sat_hold", conflict_cnt, 16'hFFFF);

    step(); a_valid = 1'b0; b_valid = 1'b0;
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
